tlb_walk_mem_port: RTL and testbench
====================================

Name: tlb_walk_mem_port

Overview:
- Memory-side responder for the TLB's walk/access bus (mem_req, mem_read, mem_paddr, mem_write_value → mem_ack, mem_read_value).
- Captures single-cycle request pulses into a small FIFO and issues them one at a time to a downstream valid/ready memory channel.
- Returns exactly one single-cycle mem_ack per accepted request.
- Sits between the TLB and the memory controller/arbiter.

Parameters:
- ADDRW, 26, physical byte-address width.
- LOG2DATAW, 5, log2 of data width (DATAW = 32).
- LOG2DEPTH, 1, log2 of request FIFO depth (2 entries).
- TIMEOUT_CYCLES, 255, read-response watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  in  1  one-cycle request pulse from the TLB.
- mem_read  in  1  1 = read, 0 = write; sampled with mem_req.
- mem_paddr  in  ADDRW  byte address; sampled only when mem_req = 1.
- mem_write_value  in  DATAW  write data; sampled with mem_req.
- mem_ack  out  1  one-cycle completion pulse.
- mem_read_value  out  DATAW  read data; valid when mem_ack = 1, otherwise holds its last value.
- dn_valid  out  1  downstream request valid.
- dn_ready  in  1  downstream accepts the request.
- dn_write  out  1  downstream write strobe.
- dn_addr  out  ADDRW  word-aligned address (low LOG2DATAW-3 bits forced to 0).
- dn_wdata  out  DATAW  downstream write data.
- dn_rvalid  in  1  downstream read data valid.
- dn_rdata  in  DATAW  downstream read data.
- busy  out  1  FIFO non-empty or state != IDLE.
- overrun  out  1  sticky: a request was dropped because the FIFO was full.
- timeout_err  out  1  sticky: watchdog fired.

Behaviour:
- Reset (asynchronous): FIFO empty, state IDLE, and all outputs 0 (mem_ack, mem_read_value, dn_valid, dn_write, dn_addr, dn_wdata, busy, overrun, timeout_err).
- Capture: the {read, paddr, wdata} triple is pushed on every clock with mem_req = 1.
  - mem_paddr is don't-care on all other cycles and must never be sampled then.
- Full FIFO: mem_req while full and no pop that cycle → request dropped, overrun set; cleared only by rst.
- Full FIFO with simultaneous pop: push is accepted.
- Only one downstream transaction is outstanding at a time.
- State machine:
  - IDLE: FIFO non-empty → ISSUE.
  - ISSUE: dn_valid = 1; dn_addr, dn_write and dn_wdata come from the FIFO head and are held stable until dn_ready.
    - On dn_valid & dn_ready, pop the head.
    - Write → ACK. Read → WAIT.
  - WAIT: on dn_rvalid, latch dn_rdata → ACK. dn_rvalid outside WAIT is ignored.
  - ACK: mem_ack = 1 for exactly one cycle, then → IDLE.
    - mem_read_value updates on the cycle mem_ack rises: latched data for a read, 0 for a write.
- Latency: mem_req at cycle N with dn_ready = 1 → read mem_ack at N+4 if dn_rvalid arrives at N+3; write mem_ack at N+3.
- Back-to-back requests: the second one is issued from IDLE in the cycle after the first ack. No ack merging or reordering.
- Reset mid-transaction abandons it: no mem_ack is issued. The downstream side is responsible for discarding any in-flight response.

Optional Feature:
- Macro: TLB_WALK_MEM_PORT_TIMEOUT_EN.
- Defined:
  - An 8-bit-plus counter (wide enough for TIMEOUT_CYCLES) counts cycles spent in WAIT.
  - When the count reaches TIMEOUT_CYCLES without dn_rvalid → ACK with mem_read_value = 0 (a non-present PTE, so the TLB takes a page fault) and timeout_err set, sticky until rst.
  - A dn_rvalid arriving after the timeout is ignored.
- Undefined: no counter; WAIT waits indefinitely; timeout_err is tied to 0. The port exists in both builds.

Decomposition:
- Package tlb_mem_pkg holds:
  - The ADDRW/DATAW/LOG2DATABYTES localparams.
  - A state enum {IDLE, ISSUE, WAIT, ACK}.
  - A request struct {read, paddr, wdata}.
- Sub-module tlb_mem_req_fifo: a parametrised-depth synchronous FIFO with push/pop/full/empty and async reset; push-when-full is allowed only when pop is also asserted.

Test Plan:
- Single read: mem_req at cycle 10 with paddr 0x0001234, dn_ready = 1, dn_rvalid at cycle 13 with rdata 0xDEAD0001 → dn_addr = 0x0001234 at cycle 12; mem_ack = 1 only at cycle 14 with mem_read_value = 0xDEAD0001.
- Unaligned write: write to 0x0000103 with wdata 0x55 → dn_addr = 0x0000100, dn_write = 1, dn_wdata = 0x55; mem_ack one cycle after dn_ready with mem_read_value = 0.
- Backpressure: hold dn_ready = 0 for 20 cycles → dn_valid/dn_addr stay stable, no mem_ack, busy = 1; exactly one ack after release.
- Overrun: three requests on consecutive cycles with dn_ready = 0 → first two are queued, third dropped, overrun = 1; exactly two acks, in order.
- Reset mid-WAIT: assert rst while in WAIT → mem_ack stays 0, busy = 0, dn_valid = 0 immediately (async), and a later dn_rvalid produces no ack.
- With TLB_WALK_MEM_PORT_TIMEOUT_EN and TIMEOUT_CYCLES = 8: read with no dn_rvalid → mem_ack 8 cycles after entering WAIT, with mem_read_value = 0 and timeout_err = 1.

Source files
------------

// File: rtl/tlb_mem_pkg.sv
// Shared types and widths for the TLB walk/access memory port.
package tlb_mem_pkg;

    localparam int ADDRW         = 26;
    localparam int LOG2DATAW     = 5;
    localparam int DATAW         = 1 << LOG2DATAW;
    localparam int LOG2DATABYTES = LOG2DATAW - 3;

    // Clears the byte-offset bits so the downstream side only ever sees word addresses.
    localparam logic [ADDRW-1:0] ALIGN_MASK = ~(ADDRW'((1 << LOG2DATABYTES) - 1));

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    typedef struct packed {
        logic             read;
        logic [ADDRW-1:0] paddr;
        logic [DATAW-1:0] wdata;
    } req_t;

    function automatic logic [ADDRW-1:0] word_align(input logic [ADDRW-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/tlb_mem_req_fifo.sv
// Small synchronous request FIFO; a push while full is taken only if the head pops in the same cycle.
module tlb_mem_req_fifo
    import tlb_mem_pkg::*;
#(
    parameter int LOG2DEPTH = 1
)
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t push_data,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << LOG2DEPTH;
    localparam logic [LOG2DEPTH:0] PTR_ONE = 1;

    req_t               mem [DEPTH];
    logic [LOG2DEPTH:0] wr_ptr;
    logic [LOG2DEPTH:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LOG2DEPTH] != rd_ptr[LOG2DEPTH]) &&
                     (wr_ptr[LOG2DEPTH-1:0] == rd_ptr[LOG2DEPTH-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[LOG2DEPTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[LOG2DEPTH-1:0]] <= push_data;
                wr_ptr                     <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tlb_walk_mem_port.sv
// Memory-side responder for the TLB walk bus: queues request pulses and serialises them downstream.
// Optional read watchdog enabled by defining TLB_WALK_MEM_PORT_TIMEOUT_EN.
module tlb_walk_mem_port
    import tlb_mem_pkg::*;
#(
    parameter int LOG2DEPTH      = 1,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             mem_read,
    input  logic [ADDRW-1:0] mem_paddr,
    input  logic [DATAW-1:0] mem_write_value,
    output logic             mem_ack,
    output logic [DATAW-1:0] mem_read_value,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic             dn_write,
    output logic [ADDRW-1:0] dn_addr,
    output logic [DATAW-1:0] dn_wdata,
    input  logic             dn_rvalid,
    input  logic [DATAW-1:0] dn_rdata,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    state_t state;
    state_t next_state;
    req_t   push_req;
    req_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   timed_out;

    assign push_req = '{read: mem_read, paddr: mem_paddr, wdata: mem_write_value};
    assign pop      = (state == ISSUE) && dn_ready;
    assign busy     = !fifo_empty || (state != IDLE);

    tlb_mem_req_fifo #(
        .LOG2DEPTH (LOG2DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_req),
        .pop       (pop),
        .push_data (push_req),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef TLB_WALK_MEM_PORT_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WDOG_W-1:0] wait_cnt;
    logic              timeout_sticky;

    // The last WAIT cycle before the limit forces completion unless real data shows up.
    assign timed_out   = (state == WAIT) && (wait_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt       <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + WDOG_W'(1) : '0;
            if (timed_out && !dn_rvalid) begin
                timeout_sticky <= 1'b1;
            end
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        dn_valid   = 1'b0;
        dn_write   = 1'b0;
        dn_addr    = '0;
        dn_wdata   = '0;
        mem_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                dn_valid = 1'b1;
                dn_write = !head.read;
                dn_addr  = word_align(head.paddr);
                dn_wdata = head.wdata;
                if (dn_ready) begin
                    next_state = head.read ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (dn_rvalid || timed_out) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                mem_ack    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Read data is loaded on the transition into ACK so it is valid alongside mem_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_value <= '0;
        end else if (pop && !head.read) begin
            mem_read_value <= '0;
        end else if ((state == WAIT) && dn_rvalid) begin
            mem_read_value <= dn_rdata;
        end else if (timed_out) begin
            mem_read_value <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (mem_req && fifo_full && !pop) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tlb_walk_mem_port.sv
// Directed self-checking bench for tlb_walk_mem_port; inputs change and outputs are checked on the falling edge.
module tb_tlb_walk_mem_port;
    import tlb_mem_pkg::*;

    logic             clk;
    logic             rst;
    logic             mem_req;
    logic             mem_read;
    logic [ADDRW-1:0] mem_paddr;
    logic [DATAW-1:0] mem_write_value;
    logic             mem_ack;
    logic [DATAW-1:0] mem_read_value;
    logic             dn_valid;
    logic             dn_ready;
    logic             dn_write;
    logic [ADDRW-1:0] dn_addr;
    logic [DATAW-1:0] dn_wdata;
    logic             dn_rvalid;
    logic [DATAW-1:0] dn_rdata;
    logic             busy;
    logic             overrun;
    logic             timeout_err;

    int total = 0;
    int bad   = 0;

    tlb_walk_mem_port #(
        .LOG2DEPTH      (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req         (mem_req),
        .mem_read        (mem_read),
        .mem_paddr       (mem_paddr),
        .mem_write_value (mem_write_value),
        .mem_ack         (mem_ack),
        .mem_read_value  (mem_read_value),
        .dn_valid        (dn_valid),
        .dn_ready        (dn_ready),
        .dn_write        (dn_write),
        .dn_addr         (dn_addr),
        .dn_wdata        (dn_wdata),
        .dn_rvalid       (dn_rvalid),
        .dn_rdata        (dn_rdata),
        .busy            (busy),
        .overrun         (overrun),
        .timeout_err     (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        mem_req         = 1'b0;
        mem_read        = 1'b0;
        mem_paddr       = 26'h3FFFFFF;
        mem_write_value = 32'hFFFFFFFF;
        dn_ready        = 1'b1;
        dn_rvalid       = 1'b0;
        dn_rdata        = 32'h0BAD0BAD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({mem_ack, dn_valid, dn_write, busy, overrun, timeout_err} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b exp=000000",
                     {mem_ack, dn_valid, dn_write, busy, overrun, timeout_err});
        end
        total++;
        if ({mem_read_value, dn_addr, dn_wdata} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_buses rv=%h addr=%h wd=%h exp=0", mem_read_value, dn_addr, dn_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        for (int c = 0; c <= 6; c++) begin
            total++;
            if (mem_ack !== (c == 4)) begin
                bad++;
                $display("[TB] FAIL read_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 4));
            end
            if (c == 2) begin
                total++;
                if (dn_valid !== 1'b1 || dn_write !== 1'b0 || dn_addr !== 26'h0001234) begin
                    bad++;
                    $display("[TB] FAIL read_issue v=%b w=%b addr=%h exp v=1 w=0 addr=0001234",
                             dn_valid, dn_write, dn_addr);
                end
            end
            if (c == 4) begin
                total++;
                if (mem_read_value !== 32'hDEAD0001) begin
                    bad++;
                    $display("[TB] FAIL read_value got=%h exp=DEAD0001", mem_read_value);
                end
            end
            idle_inputs();
            mem_req   = (c == 0);
            mem_read  = 1'b1;
            mem_paddr = (c == 0) ? 26'h0001234 : 26'h3FFFFFF;
            // A stray response while IDLE must be ignored.
            dn_rvalid = (c == 1) || (c == 3);
            dn_rdata  = (c == 3) ? 32'hDEAD0001 : 32'h0BAD0BAD;
            @(negedge clk);
        end
    endtask

    task automatic test_unaligned_write();
        for (int c = 0; c <= 4; c++) begin
            total++;
            if (mem_ack !== (c == 3)) begin
                bad++;
                $display("[TB] FAIL write_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 3));
            end
            if (c == 2) begin
                total++;
                if (dn_valid !== 1'b1 || dn_write !== 1'b1 || dn_addr !== 26'h0000100 || dn_wdata !== 32'h55) begin
                    bad++;
                    $display("[TB] FAIL write_issue v=%b w=%b addr=%h wd=%h exp v=1 w=1 addr=0000100 wd=55",
                             dn_valid, dn_write, dn_addr, dn_wdata);
                end
            end
            if (c == 3) begin
                total++;
                if (mem_read_value !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL write_rvalue got=%h exp=0", mem_read_value);
                end
            end
            idle_inputs();
            mem_req         = (c == 0);
            mem_paddr       = (c == 0) ? 26'h0000103 : 26'h3FFFFFF;
            mem_write_value = (c == 0) ? 32'h55 : 32'hFFFFFFFF;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int acks = 0;
        for (int c = 0; c <= 29; c++) begin
            if (c >= 2 && c <= 21) begin
                total++;
                if (dn_valid !== 1'b1 || dn_addr !== 26'h0ABCDE8 || dn_wdata !== 32'h12345678 ||
                    mem_ack !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL bp_hold c=%0d v=%b addr=%h wd=%h ack=%b busy=%b exp v=1 addr=0ABCDE8 wd=12345678 ack=0 busy=1",
                             c, dn_valid, dn_addr, dn_wdata, mem_ack, busy);
                end
            end
            if (mem_ack === 1'b1) acks++;
            idle_inputs();
            mem_req         = (c == 0);
            mem_paddr       = (c == 0) ? 26'h0ABCDE8 : 26'h3FFFFFF;
            mem_write_value = (c == 0) ? 32'h12345678 : 32'hFFFFFFFF;
            dn_ready        = (c >= 21);
            @(negedge clk);
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("[TB] FAIL bp_ack_count got=%0d exp=1", acks);
        end
    endtask

    task automatic test_overrun();
        logic [ADDRW-1:0] issued[$];
        int acks = 0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 2) begin
                total++;
                if (overrun !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL ovr_early got=%b exp=0", overrun);
                end
            end
            if (c == 3) begin
                total++;
                if (overrun !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL ovr_set got=%b exp=1", overrun);
                end
            end
            if (mem_ack === 1'b1) acks++;
            idle_inputs();
            mem_req         = (c <= 2);
            mem_paddr       = (c <= 2) ? ADDRW'((c + 1) * 16) : 26'h3FFFFFF;
            mem_write_value = 32'(c + 1);
            dn_ready        = (c >= 3);
            if (dn_valid === 1'b1 && dn_ready) issued.push_back(dn_addr);
            @(negedge clk);
        end
        total++;
        if (acks != 2) begin
            bad++;
            $display("[TB] FAIL ovr_ack_count got=%0d exp=2", acks);
        end
        total++;
        if (issued.size() != 2) begin
            bad++;
            $display("[TB] FAIL ovr_issue_count got=%0d exp=2", issued.size());
        end else if (issued[0] !== 26'h10 || issued[1] !== 26'h20) begin
            bad++;
            $display("[TB] FAIL ovr_order got=%h,%h exp=0000010,0000020", issued[0], issued[1]);
        end
        total++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovr_end busy=%b ovr=%b exp busy=0 ovr=1", busy, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_valid;
        for (int c = 0; c <= 9; c++) begin
            total++;
            if (mem_ack !== (c == 3 || c == 7)) begin
                bad++;
                $display("[TB] FAIL b2b_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 3 || c == 7));
            end
            exp_valid = (c == 2 || c == 5);
            total++;
            if (dn_valid !== exp_valid) begin
                bad++;
                $display("[TB] FAIL b2b_valid c=%0d got=%b exp=%b", c, dn_valid, exp_valid);
            end
            if (c == 2 || c == 5) begin
                total++;
                if (dn_addr !== ((c == 2) ? 26'h0000200 : 26'h0000304)) begin
                    bad++;
                    $display("[TB] FAIL b2b_addr c=%0d got=%h exp=%h", c, dn_addr,
                             (c == 2) ? 26'h0000200 : 26'h0000304);
                end
            end
            if (c == 3 || c == 7) begin
                total++;
                if (mem_read_value !== ((c == 3) ? 32'h0 : 32'h13579BDF)) begin
                    bad++;
                    $display("[TB] FAIL b2b_rvalue c=%0d got=%h exp=%h", c, mem_read_value,
                             (c == 3) ? 32'h0 : 32'h13579BDF);
                end
            end
            idle_inputs();
            mem_req         = (c <= 1);
            mem_read        = (c == 1);
            mem_paddr       = (c == 0) ? 26'h0000200 : ((c == 1) ? 26'h0000306 : 26'h3FFFFFF);
            mem_write_value = (c == 0) ? 32'hAA : 32'hFFFFFFFF;
            dn_rvalid       = (c == 6);
            dn_rdata        = (c == 6) ? 32'h13579BDF : 32'h0BAD0BAD;
            @(negedge clk);
        end
    endtask

`ifdef TLB_WALK_MEM_PORT_TIMEOUT_EN
    task automatic test_timeout();
        for (int c = 0; c <= 15; c++) begin
            total++;
            if (mem_ack !== (c == 11)) begin
                bad++;
                $display("[TB] FAIL tmo_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 11));
            end
            if (c == 10) begin
                total++;
                if (timeout_err !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL tmo_early got=%b exp=0", timeout_err);
                end
            end
            if (c == 11) begin
                total++;
                if (mem_read_value !== 32'h0 || timeout_err !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL tmo_fire rv=%h err=%b exp rv=0 err=1", mem_read_value, timeout_err);
                end
            end
            idle_inputs();
            mem_req   = (c == 0);
            mem_read  = 1'b1;
            mem_paddr = (c == 0) ? 26'h0000080 : 26'h3FFFFFF;
            dn_rvalid = (c == 12);
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || mem_read_value !== 32'h0) begin
            bad++;
            $display("[TB] FAIL tmo_end busy=%b err=%b rv=%h exp busy=0 err=1 rv=0", busy, timeout_err, mem_read_value);
        end
    endtask
`else
    task automatic test_wait_forever();
        for (int c = 0; c <= 38; c++) begin
            total++;
            if (mem_ack !== (c == 36)) begin
                bad++;
                $display("[TB] FAIL wait_ack c=%0d got=%b exp=%b", c, mem_ack, (c == 36));
            end
            if (c == 30) begin
                total++;
                if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL wait_hold busy=%b err=%b exp busy=1 err=0", busy, timeout_err);
                end
            end
            if (c == 36) begin
                total++;
                if (mem_read_value !== 32'hCAFEF00D) begin
                    bad++;
                    $display("[TB] FAIL wait_rvalue got=%h exp=CAFEF00D", mem_read_value);
                end
            end
            idle_inputs();
            mem_req   = (c == 0);
            mem_read  = 1'b1;
            mem_paddr = (c == 0) ? 26'h0000040 : 26'h3FFFFFF;
            dn_rvalid = (c == 35);
            dn_rdata  = (c == 35) ? 32'hCAFEF00D : 32'h0BAD0BAD;
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            mem_req   = (c == 0);
            mem_read  = 1'b1;
            mem_paddr = (c == 0) ? 26'h0000044 : 26'h3FFFFFF;
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b1 || dn_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmw_pre busy=%b v=%b exp busy=1 v=0", busy, dn_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (mem_ack !== 1'b0 || busy !== 1'b0 || dn_valid !== 1'b0 || overrun !== 1'b0 ||
            timeout_err !== 1'b0 || mem_read_value !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rmw_async ack=%b busy=%b v=%b ovr=%b err=%b rv=%h exp all 0",
                     mem_ack, busy, dn_valid, overrun, timeout_err, mem_read_value);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            dn_rvalid = (c <= 1);
            dn_rdata  = 32'h77777777;
            @(negedge clk);
            total++;
            if (mem_ack !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rmw_after c=%0d ack=%b busy=%b exp ack=0 busy=0", c, mem_ack, busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_unaligned_write();
        test_backpressure();
        test_overrun();
        test_back_to_back();
`ifdef TLB_WALK_MEM_PORT_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
